// File: rtl/measure_pkg.sv
// Shared register offsets, result layout and read-FSM states
// for the measurement result reader.
package measure_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_SIG    = 2'd1;
  localparam logic [1:0] REG_REF    = 2'd2;
  localparam logic [1:0] REG_TS     = 2'd3;

  typedef struct packed {
    logic [31:0] ref_sum;
    logic [31:0] sig_sum;
  } meas_result_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with first-word fall-through head.
// Ports: clk_i, rst_i (sync, high), push_i, pop_i, wdata_i,
// full_o, empty_o, count_o (0..DEPTH), head_o (valid when !empty_o).
// The caller must not push while full without a same-cycle pop,
// and must not pop while empty.
module result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/measure_reader.sv
// Buffers 64-bit {ref, sig} measurement results in a FIFO and
// serves them over a read-only AXI4-Lite slave (AR/R only).
// Ports: clk_i, rst_i (sync, high); reg_wr_en_i/reg_wr_data_i
// result push; s_axi_ar*/s_axi_r* read channels; data_avail_o
// FIFO non-empty level. Define MEASURE_READER_TS_EN to store a
// free-running cycle timestamp with each entry (offset 0xC).
module measure_reader
  import measure_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_wr_en_i,
  input  logic [63:0]           reg_wr_data_i,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr_i,
  input  logic                  s_axi_arvalid_i,
  output logic                  s_axi_arready_o,
  output logic [31:0]           s_axi_rdata_o,
  output logic [1:0]            s_axi_rresp_o,
  output logic                  s_axi_rvalid_o,
  input  logic                  s_axi_rready_i,
  output logic                  data_avail_o
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef MEASURE_READER_TS_EN
  localparam int FW = 96;
`else
  localparam int FW = 64;
`endif

  rd_state_t    state_q, state_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         ovf_q, ovf_d;

  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic [FW-1:0] fifo_wdata, fifo_head;
  meas_result_t  head_res;
  logic [31:0]   head_ts;
  logic [1:0]    reg_sel;
  logic          unused_addr;

`ifdef MEASURE_READER_TS_EN
  logic [31:0] ts_q, ts_d;

  assign ts_d = ts_q + 32'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign fifo_wdata = {ts_q, reg_wr_data_i};
  assign head_ts    = fifo_head[95:64];
`else
  assign fifo_wdata = reg_wr_data_i;
  assign head_ts    = '0;
`endif

  assign head_res    = meas_result_t'(fifo_head[63:0]);
  assign count8      = 8'(count);
  assign reg_sel     = s_axi_araddr_i[3:2];
  assign unused_addr = ^s_axi_araddr_i;

  result_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (s_axi_arvalid_i) begin
          state_d = RD_RESP;
          unique case (reg_sel)
            REG_STATUS: begin
              rdata_d = {23'b0, ovf_q, count8};
              ovf_d   = 1'b0;
            end
            REG_SIG: rdata_d = empty ? '0 : head_res.sig_sum;
            REG_REF: begin
              rdata_d = empty ? '0 : head_res.ref_sum;
              pop     = !empty;
            end
            REG_TS:  rdata_d = empty ? '0 : head_ts;
          endcase
        end
      end
      RD_RESP: begin
        if (s_axi_rready_i) state_d = RD_IDLE;
      end
    endcase
    // A pop frees a slot in the same cycle, so a full FIFO
    // still takes the push. Overflow wins over a STATUS clear.
    push = reg_wr_en_i & (!full | pop);
    if (reg_wr_en_i & full & !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s_axi_arready_o = (state_q == RD_IDLE);
  assign s_axi_rvalid_o  = (state_q == RD_RESP);
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = 2'b00;
  assign data_avail_o    = !empty;

endmodule

// File: tb/tb_measure_reader.sv
// Scoreboard bench for measure_reader: reference model of the
// FIFO/register behaviour, monitor checks every R response.
module tb_measure_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        avail;

  always #5 clk = ~clk;

  measure_reader #(.DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .reg_wr_en_i     (wr_en),
    .reg_wr_data_i   (wr_data),
    .s_axi_araddr_i  (araddr),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .data_avail_o    (avail)
  );

  typedef struct {
    logic [63:0] d;
    logic [31:0] ts;
  } ent_t;

  ent_t        fifo_m[$];
  logic [31:0] exp_q[$];
  bit          ovf_m;
  bit          busy_m;
  logic [31:0] cyc_m;
  int          tests;
  int          fails;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               n, act, exp, $time);
    end
  endfunction

  // Effect of the coming clock edge given the driven inputs.
  function automatic void model_edge();
    bit acc, pop, full, ovf_set, ovf_clr;
    logic [31:0] val;
    if (rst) begin
      fifo_m.delete();
      exp_q.delete();
      ovf_m  = 0;
      busy_m = 0;
      cyc_m  = '0;
      return;
    end
    acc = arvalid && !busy_m;
    pop = 0;
    ovf_set = 0;
    ovf_clr = 0;
    if (busy_m && rready) busy_m = 0;
    if (acc) begin
      val = '0;
      case (araddr[3:2])
        2'd0: begin
          val = {23'b0, ovf_m, 8'(fifo_m.size())};
          ovf_clr = 1;
        end
        2'd1: if (fifo_m.size() > 0) val = fifo_m[0].d[31:0];
        2'd2: if (fifo_m.size() > 0) begin
          val = fifo_m[0].d[63:32];
          pop = 1;
        end
        default: begin
`ifdef MEASURE_READER_TS_EN
          if (fifo_m.size() > 0) val = fifo_m[0].ts;
`endif
        end
      endcase
      exp_q.push_back(val);
      busy_m = 1;
    end
    full = (fifo_m.size() == DEPTH);
    if (pop) void'(fifo_m.pop_front());
    if (wr_en) begin
      if (!full || pop) fifo_m.push_back('{wr_data, cyc_m});
      else ovf_set = 1;
    end
    if (ovf_clr) ovf_m = 0;
    if (ovf_set) ovf_m = 1;
    cyc_m = cyc_m + 32'd1;
  endfunction

  task automatic cycle(input bit r, input bit w,
                       input logic [63:0] d, input bit av,
                       input logic [3:0] a, input bit rr);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    arvalid = av;
    araddr  = a;
    rready  = rr;
    model_edge();
    @(posedge clk);
    #1;
    chk("arready", 32'(arready), 32'(!busy_m));
    chk("rvalid", 32'(rvalid), 32'(busy_m));
    chk("data_avail", 32'(avail), 32'(fifo_m.size() > 0));
    if (r) chk("rdata_rst", rdata, 32'h0);
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 4'h0, 1);
  endtask

  task automatic push(input logic [63:0] d);
    cycle(0, 1, d, 0, 4'h0, 1);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(0, 0, '0, 1, a, 1);
    cycle(0, 0, '0, 0, 4'h0, 1);
  endtask

  // Monitor: compare each R beat; hold checks while stalled.
  always @(negedge clk) begin
    if (rst !== 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rdata: got %h with no expected entry",
                 rdata);
      end else if (rready) begin
        chk("rdata", rdata, exp_q.pop_front());
        chk("rresp", 32'(rresp), 32'h0);
      end else begin
        chk("rdata_hold", rdata, exp_q[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    cycle(1, 0, '0, 0, 4'h0, 0);
    cycle(1, 0, '0, 0, 4'h0, 0);

    rd(4'h0);
    push(64'h0000_0010_0000_0004);
    rd(4'h4);
    rd(4'h8);
    rd(4'h0);

    for (int i = 0; i < 5; i++)
      push({$urandom, $urandom});
    rd(4'h0);
    for (int i = 0; i < 4; i++) begin
      rd(4'h4);
      rd(4'h8);
    end
    rd(4'h0);
    rd(4'h8);

    for (int i = 0; i < 4; i++)
      push({$urandom, $urandom});
    cycle(0, 1, 64'hAAAA_5555_1234_5678, 1, 4'h8, 1);
    idle();
    rd(4'h0);
    for (int i = 0; i < 4; i++) rd(4'h8);

    push(64'h1111_2222_3333_4444);
    cycle(0, 0, '0, 1, 4'h4, 0);
    repeat (10) cycle(0, 0, '0, 1, 4'h0, 0);
    cycle(0, 0, '0, 0, 4'h0, 1);
    rd(4'h8);

    cycle(1, 0, '0, 0, 4'h0, 0);
    while (cyc_m != 32'd100) idle();
    push(64'h0000_0001_0000_0002);
    while (cyc_m != 32'd250) idle();
    push(64'h0000_0003_0000_0004);
    rd(4'hC);
    rd(4'h8);
    rd(4'hC);
    rd(4'h8);
    rd(4'hC);

    push(64'h0000_0005_0000_0006);
    cycle(0, 0, '0, 1, 4'h4, 0);
    cycle(0, 0, '0, 0, 4'h0, 0);
    cycle(1, 0, '0, 0, 4'h0, 0);
    idle();

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 149) == 0,
            $urandom_range(0, 2) == 0,
            {$urandom, $urandom},
            $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 4) != 0);
    end

    repeat (4) idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
